// File: rtl/ram_bus_pkg.sv
// Shared widths and FSM state encoding for the RAM bus master.
package ram_bus_pkg;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;
endpackage

// File: rtl/ram_bus_master.sv
// Single-request master for an asynchronous 16x8 RAM with a shared tri-state
// data bus: setup, WAIT_CYCLES strobe, hold/turnaround, then a response handshake.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_we,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        wait_cnt;
  logic              wr_q;
  logic [DATA_W-1:0] dout;
  logic              doe;
  logic              accept;
  logic              wr_nx;

  assign accept = req_valid && req_ready && (state == IDLE);
  // Direction of the upcoming cycle, valid on the accepting edge before wr_q loads.
  assign wr_nx  = accept ? req_write : wr_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (wait_cnt == '0) state_nx = HOLD;
      HOLD:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they change with the FSM edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_we    <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      dout      <= '0;
      doe       <= 1'b0;
      wr_q      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= (state_nx == IDLE);
      rsp_valid <= (state_nx == RESP);
      ram_we    <= (state_nx == STROBE) && wr_nx;
      ram_en    <= (state_nx == STROBE) && !wr_nx;
      doe       <= wr_nx && (state_nx inside {SETUP, STROBE, HOLD});
      if (accept) begin
        wr_q      <= req_write;
        ram_addr  <= req_addr;
        dout      <= req_wdata;
        rsp_rdata <= '0;
      end
      if (state == SETUP)
        wait_cnt <= WAIT_LOAD;
      else if ((state == STROBE) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 4'd1;
      if ((state == STROBE) && (wait_cnt == '0) && !wr_q)
        rsp_rdata <= ram_data;
    end
  end

  assign ram_data = doe ? dout : 'z;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two instances (WAIT_CYCLES 1 and 4), each with a
// behavioural 16x8 RAM on its bus, checked against a transaction-level model.
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid[2], req_write[2], rsp_ready[2];
  logic [3:0] req_addr[2];
  logic [7:0] req_wdata[2];
  logic       req_ready[2], rsp_valid[2], ram_we[2], ram_en[2];
  logic [3:0] ram_addr[2];
  logic [7:0] rsp_rdata[2];
  wire  [7:0] bus0, bus1;
  logic [7:0] busv[2];
  logic       busz[2];

  logic [7:0] mem0[16] = '{default: 8'h00};
  logic [7:0] mem1[16] = '{15: 8'h5C, default: 8'h00};
  logic [7:0] ref_mem[2][16];

  int n_chk = 0;
  int n_fail = 0;

  ram_bus_master #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .ram_we(ram_we[0]), .ram_en(ram_en[0]), .ram_addr(ram_addr[0]), .ram_data(bus0)
  );

  ram_bus_master #(.WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .ram_we(ram_we[1]), .ram_en(ram_en[1]), .ram_addr(ram_addr[1]), .ram_data(bus1)
  );

  // Asynchronous RAMs: drive while read-enabled, capture while write-strobed.
  assign bus0 = (ram_en[0] && !ram_we[0]) ? mem0[ram_addr[0]] : 8'hzz;
  assign bus1 = (ram_en[1] && !ram_we[1]) ? mem1[ram_addr[1]] : 8'hzz;
  always @(posedge clk) if (ram_we[0] && !ram_en[0]) mem0[ram_addr[0]] <= bus0;
  always @(posedge clk) if (ram_we[1] && !ram_en[1]) mem1[ram_addr[1]] <= bus1;

  assign busv[0] = bus0;
  assign busv[1] = bus1;
  assign busz[0] = (bus0 === 8'hzz);
  assign busz[1] = (bus1 === 8'hzz);

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) chkb("we_en_exclusive", ram_we[k] && ram_en[k], 1'b0);
    end
  end

  // One complete transaction with optional response stall; timing and bus checked from the model.
  task automatic txn(input int k, input bit wr, input logic [3:0] a, input logic [7:0] d,
                     input int hold, output logic [7:0] rd);
    int n, we_n, en_n;
    bit ok_addr, ok_bus, ok_rdy, ok_stall;
    logic [7:0] exp_rd;
    exp_rd = wr ? 8'h00 : ref_mem[k][a];
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chkb("req_ready_idle", req_ready[k], 1'b1);
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_write[k] = 1'($urandom);
    req_addr[k] = 4'($urandom); req_wdata[k] = 8'($urandom);
    n = 0; we_n = 0; en_n = 0; ok_addr = 1; ok_bus = 1; ok_rdy = 1;
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      if (ram_we[k]) we_n++;
      if (ram_en[k]) en_n++;
      if (ram_addr[k] !== a) ok_addr = 0;
      if (req_ready[k] !== 1'b0) ok_rdy = 0;
      if (wr) begin
        if (busz[k] || busv[k] !== d) ok_bus = 0;
      end else if (ram_en[k] ? (busv[k] !== exp_rd) : !busz[k]) ok_bus = 0;
      @(posedge clk); #1; n++;
    end
    chki("rsp_latency", n, 2 + wc(k));
    chki("we_cycles", we_n, wr ? wc(k) : 0);
    chki("en_cycles", en_n, wr ? 0 : wc(k));
    chkb("addr_stable", ok_addr, 1'b1);
    chkb("bus_drive", ok_bus, 1'b1);
    chkb("ready_low_busy", ok_rdy, 1'b1);
    chkb("bus_z_resp", busz[k], 1'b1);
    chk8("rsp_rdata", rsp_rdata[k], exp_rd);
    rd = rsp_rdata[k];
    ok_stall = 1;
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1; req_write[k] = 1'b1; req_addr[k] = a; req_wdata[k] = ~d;
      @(posedge clk); #1;
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rd || req_ready[k] !== 1'b0 ||
          ram_we[k] || ram_en[k]) ok_stall = 0;
    end
    if (hold > 0) chkb("stall_stable", ok_stall, 1'b1);
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chkb("rsp_valid_drop", rsp_valid[k], 1'b0);
    chkb("req_ready_back", req_ready[k], 1'b1);
    if (wr) ref_mem[k][a] = d;
  endtask

  typedef struct {
    int         k;
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] rd, d;
  bit         flag;
  int         n;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; rsp_ready[k] = 1'b0;
      for (int a = 0; a < 16; a++) ref_mem[k][a] = 8'h00;
    end
    ref_mem[1][15] = 8'h5C;

    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chkb("rst_req_ready", req_ready[k], 1'b0);
      chkb("rst_rsp_valid", rsp_valid[k], 1'b0);
      chk8("rst_rsp_rdata", rsp_rdata[k], 8'h00);
      chkb("rst_ram_we", ram_we[k], 1'b0);
      chkb("rst_ram_en", ram_en[k], 1'b0);
      chki("rst_ram_addr", int'(ram_addr[k]), 0);
      chkb("rst_bus_z", busz[k], 1'b1);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("ready_after_rst0", req_ready[0], 1'b1);
    chkb("ready_after_rst1", req_ready[1], 1'b1);

    vecs[0] = '{k: 0, wr: 1, a: 4'h3, d: 8'hA5, hold: 0, exp: 8'h00};
    vecs[1] = '{k: 0, wr: 0, a: 4'h3, d: 8'h00, hold: 0, exp: 8'hA5};
    vecs[2] = '{k: 1, wr: 0, a: 4'hF, d: 8'h00, hold: 0, exp: 8'h5C};
    vecs[3] = '{k: 0, wr: 1, a: 4'h7, d: 8'h3C, hold: 5, exp: 8'h00};
    vecs[4] = '{k: 0, wr: 0, a: 4'h7, d: 8'h00, hold: 5, exp: 8'h3C};
    vecs[5] = '{k: 1, wr: 1, a: 4'h0, d: 8'h81, hold: 2, exp: 8'h00};
    vecs[6] = '{k: 1, wr: 0, a: 4'h0, d: 8'h00, hold: 0, exp: 8'h81};
    foreach (vecs[i]) begin
      txn(vecs[i].k, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].hold, rd);
      chk8("vec_rdata", rd, vecs[i].exp);
    end

    // Reset pulse during a write strobe on the WAIT_CYCLES=1 instance.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 4'h9; req_wdata[0] = 8'h66;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chkb("abort_in_strobe", ram_we[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkb("abort_we_low", ram_we[0], 1'b0);
    chkb("abort_bus_z", busz[0], 1'b1);
    chkb("abort_ready_low", req_ready[0], 1'b0);
    chki("abort_addr_zero", int'(ram_addr[0]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("abort_ready_edge", req_ready[0], 1'b1);
    flag = 1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid[0] !== 1'b0) flag = 0;
      @(posedge clk); #1;
    end
    chkb("abort_no_rsp", flag, 1'b1);

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) begin
        d = 8'($urandom);
        txn(k, 1'b1, 4'(a), d, int'($urandom_range(0, 2)), rd);
        txn(k, 1'b0, 4'(a), 8'h00, int'($urandom_range(0, 1)), rd);
      end
      for (int i = 0; i < 16; i++)
        txn(k, 1'b0, 4'($urandom), 8'h00, 0, rd);
    end

    n = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
